// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: definitions shared by the fetch queue, its interface and the bench.
//   FQ_XLEN             default address/instruction width
//   INSTR_NOP           word presented on instr_o while no head is valid
//   fetch_state_t       FS_FETCH (issuing) / FS_DRAIN (discarding stale responses)
//   fetch_queue_entry_t one queued instruction with the PC it was fetched from
package fetch_queue_pkg;

   localparam int FQ_XLEN = 32;
   localparam logic [31:0] INSTR_NOP = 32'h00000013;

   typedef enum logic {
      FS_FETCH = 1'b0,
      FS_DRAIN = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [FQ_XLEN-1:0] pc;
      logic [FQ_XLEN-1:0] instr;
   } fetch_queue_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: imem request/response, redirect and decode handshake bundle.
//   master : the fetch queue (drives imem requests and the decode head)
//   slave  : the environment (imem, EX/MEM redirect source, decode)
interface fetch_queue_if
   import fetch_queue_pkg::*;
#(
   parameter int XLEN = FQ_XLEN
);
   logic            imem_rd_valid_o;
   logic [XLEN-1:0] imem_rd_addr_o;
   logic            imem_rd_ready_i;
   logic            imem_rsp_valid_i;
   logic [XLEN-1:0] imem_rsp_data_i;
   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            instr_valid_o;
   logic [XLEN-1:0] instr_o;
   logic [XLEN-1:0] pc_o;
   logic            instr_ready_i;

   modport master (
      output imem_rd_valid_o, imem_rd_addr_o,
      input  imem_rd_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
      input  redirect_i, redirect_pc_i,
      output instr_valid_o, instr_o, pc_o,
      input  instr_ready_i
   );

   modport slave (
      input  imem_rd_valid_o, imem_rd_addr_o,
      output imem_rd_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
      output redirect_i, redirect_pc_i,
      input  instr_valid_o, instr_o, pc_o,
      output instr_ready_i
   );
endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// sync_fifo: WIDTH x DEPTH synchronous FIFO with flush (DEPTH a power of two).
//   clk_i, reset_i : clock, synchronous active-high reset
//   flush_i        : empty the FIFO next cycle (overrides write/read)
//   wr_en_i/wr_data_i : push; ignored when full (flagged by assertion)
//   rd_en_i        : pop head; ignored when empty
//   rd_data_o      : head entry (combinational read)
//   count_o        : occupancy, 0..DEPTH
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic [CW-1:0]    count_o
);
   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]               count_q, count_d;
   logic                        full, empty, do_wr, do_rd;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign do_wr = wr_en_i && !full;
   assign do_rd = rd_en_i && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);   // wraps mod DEPTH
         end
         if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(do_wr) - CW'(do_rd);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
      mem_q <= mem_d;   // storage needs no reset; count gates its visibility
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   // Callers size requests by credit, so a push into a full FIFO is a bug upstream.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
      !(wr_en_i && full && !flush_i));
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC generator + in-order DEPTH-entry instruction queue between
// the imem port and decode. Requests are issued only while a queue slot is
// guaranteed for their response; a redirect flushes the queue and drains the
// responses still owed by imem before fetching from the new target.
//   clk_i, reset_i : clock, synchronous active-high reset
//   bus (master)   : imem request/response, redirect, decode head handshake
// Optional: FETCH_QUEUE_BYPASS_EN - a response arriving while the queue is
// empty is forwarded to decode in the same cycle (written only if not taken).
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int              XLEN     = FQ_XLEN,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h00010000)
) (
   input  logic       clk_i,
   input  logic       reset_i,
   fetch_queue_if.master bus
);
   localparam int CW = $clog2(DEPTH + 1);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   stale_q, stale_d;

   logic [CW-1:0]     q_count, t_count;
   logic [2*XLEN-1:0] q_wr_data, q_rd_data;
   logic [XLEN-1:0]   t_rd_data;
   logic              q_empty, q_wr_en, q_rd_en;
   logic              credit, rd_valid, accept, rsp, live_rsp, byp, head_valid, dequeue;

   assign q_empty = (q_count == '0);
   assign credit  = ({1'b0, q_count} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);
   assign rd_valid = !reset_i && (state_q == FS_FETCH) && credit;
   assign accept   = rd_valid && bus.imem_rd_ready_i;
   assign rsp      = bus.imem_rsp_valid_i;
   // A response is kept only in FS_FETCH with no redirect this cycle; all others are stale.
   assign live_rsp = rsp && (state_q == FS_FETCH) && !bus.redirect_i;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign byp = live_rsp && q_empty;
`else
   assign byp = 1'b0;
`endif

   assign head_valid = !q_empty || byp;
   assign dequeue    = !reset_i && head_valid && bus.instr_ready_i;
   assign q_rd_en    = dequeue && !q_empty && !bus.redirect_i;
   assign q_wr_en    = live_rsp && !(byp && bus.instr_ready_i);
   assign q_wr_data  = {t_rd_data, bus.imem_rsp_data_i};   // {pc, instr} like fetch_queue_entry_t

   sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_instr_q (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .flush_i   (bus.redirect_i),
      .wr_en_i   (q_wr_en),
      .wr_data_i (q_wr_data),
      .rd_en_i   (q_rd_en),
      .rd_data_o (q_rd_data),
      .count_o   (q_count)
   );

   // PC of every outstanding request, oldest at the head; popped by its response.
   sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .flush_i   (bus.redirect_i),
      .wr_en_i   (accept),
      .wr_data_i (fetch_pc_q),
      .rd_en_i   (live_rsp),
      .rd_data_o (t_rd_data),
      .count_o   (t_count)
   );

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      inflight_d = inflight_q;
      stale_d    = stale_q;
      if (bus.redirect_i) begin
         fetch_pc_d = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
         // Everything imem still owes us becomes stale; inflight and stale are
         // never both nonzero, so their sum is the outstanding count in any state.
         stale_d    = inflight_q + stale_q + CW'(accept) - CW'(rsp);
         inflight_d = '0;
         state_d    = (stale_d != '0) ? FS_DRAIN : FS_FETCH;
      end else begin
         case (state_q)
            FS_FETCH: begin
               if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
               inflight_d = inflight_q + CW'(accept) - CW'(rsp);
            end
            FS_DRAIN: begin
               stale_d = stale_q - CW'(rsp);
               if (stale_d == '0) state_d = FS_FETCH;
            end
            default: state_d = FS_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= FS_FETCH;
         fetch_pc_q <= RESET_PC;
         inflight_q <= '0;
         stale_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         stale_q    <= stale_d;
      end
   end

   always_comb begin
      bus.imem_rd_valid_o = rd_valid;
      bus.imem_rd_addr_o  = fetch_pc_q;
      bus.instr_valid_o   = !reset_i && head_valid;
      bus.instr_o         = XLEN'(INSTR_NOP);
      bus.pc_o            = '0;
      if (reset_i) begin
         bus.instr_o = '0;
      end else if (byp) begin
         bus.instr_o = bus.imem_rsp_data_i;
         bus.pc_o    = t_rd_data;
      end else if (!q_empty) begin
         bus.instr_o = q_rd_data[XLEN-1:0];
         bus.pc_o    = q_rd_data[2*XLEN-1:XLEN];
      end
   end

   a_tag_tracks_inflight: assert property (@(posedge clk_i) disable iff (reset_i)
      t_count == inflight_q);
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h00010000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_queue_if #(.XLEN(32)) bus ();

   fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   typedef struct { logic [31:0] addr; int due; } req_t;

   int total = 0, bad = 0;
   int cyc = 0, last_due = 0;
   req_t pend[$];

   // reference: the stream since the last reset/redirect is simply sequential PCs
   logic [31:0] exp_req, exp_head;
   int outst;
   int acc_cnt, deq_cnt;

   // knobs
   int lat_min = 1, lat_max = 1, p_rdy = 100, p_irdy = 100, p_redir = 0, p_rst = 0;
   logic force_redir = 0;
   logic [31:0] force_pc = '0;

   // per-cycle samples
   logic s_rst, s_rdv, s_acc, s_iv, s_deq, s_rsp, s_redir;
   logic [31:0] s_addr, s_pc, s_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: drive at posedge+1, sample/check at negedge, return at next posedge+1.
   task automatic step();
      logic [31:0] rpc;
      cyc++;
      rst = rst || ($urandom_range(999) < p_rst);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         bus.imem_rsp_valid_i = 1'b1;
         bus.imem_rsp_data_i  = mem_word(pend[0].addr);
      end else begin
         bus.imem_rsp_valid_i = 1'b0;
         bus.imem_rsp_data_i  = $urandom;
      end
      bus.imem_rd_ready_i = ($urandom_range(99) < p_rdy);
      bus.instr_ready_i   = ($urandom_range(99) < p_irdy);
      rpc = $urandom;
      bus.redirect_i      = force_redir || ($urandom_range(99) < p_redir);
      bus.redirect_pc_i   = force_redir ? force_pc : rpc;

      @(negedge clk);
      s_rst   = rst;
      s_rdv   = bus.imem_rd_valid_o;
      s_addr  = bus.imem_rd_addr_o;
      s_acc   = s_rdv && bus.imem_rd_ready_i;
      s_iv    = bus.instr_valid_o;
      s_pc    = bus.pc_o;
      s_instr = bus.instr_o;
      s_deq   = s_iv && bus.instr_ready_i;
      s_rsp   = bus.imem_rsp_valid_i;
      s_redir = bus.redirect_i;

      if (s_rst) begin
         chk("rst_rd_valid", {31'd0, s_rdv}, 32'd0);
         chk("rst_instr_valid", {31'd0, s_iv}, 32'd0);
         chk("rst_instr", s_instr, 32'd0);
         chk("rst_pc", s_pc, 32'd0);
         pend.delete();
         last_due = 0;
         exp_req  = RESET_PC;
         exp_head = RESET_PC;
         outst    = 0;
      end else begin
         if (s_iv) begin
            chk("head_pc", s_pc, exp_head);
            chk("head_instr", s_instr, mem_word(s_pc));
            if (s_deq) begin
               exp_head += 4;
               outst--;
               deq_cnt++;
            end
         end
         if (s_rdv) begin
            chk("req_addr", s_addr, exp_req);
            if (s_acc) begin
               int d;
               d = cyc + int'($urandom_range(lat_max, lat_min));
               if (d <= last_due) d = last_due + 1;
               last_due = d;
               pend.push_back('{addr: s_addr, due: d});
               exp_req += 4;
               outst++;
               acc_cnt++;
               chk("credit", {31'd0, outst <= DEPTH}, 32'd1);
            end
         end
         if (s_rsp) void'(pend.pop_front());
         if (s_redir) begin
            exp_req  = {bus.redirect_pc_i[31:2], 2'b00};
            exp_head = exp_req;
            outst    = 0;
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
   endtask

   task automatic knobs(input int lmin, input int lmax, input int prdy, input int pirdy,
                        input int pred, input int prst);
      lat_min = lmin; lat_max = lmax; p_rdy = prdy; p_irdy = pirdy;
      p_redir = pred; p_rst = prst;
   endtask

   initial begin
      int first_req, redir_cyc;
      logic got_it;
      rst = 1'b1;
      bus.imem_rd_ready_i = 0; bus.imem_rsp_valid_i = 0; bus.imem_rsp_data_i = '0;
      bus.redirect_i = 0; bus.redirect_pc_i = '0; bus.instr_ready_i = 0;
      exp_req = RESET_PC; exp_head = RESET_PC; outst = 0; acc_cnt = 0; deq_cnt = 0;
      @(posedge clk); #1;

      // 1: straight-line streaming, latency 1
      knobs(1, 1, 100, 100, 0, 0);
      do_reset();
      step();
      chk("first_req_valid", {31'd0, s_rdv}, 32'd1);
      chk("first_req_addr", s_addr, RESET_PC);
      step();
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("bypass_same_cycle", {31'd0, s_iv}, 32'd1);
`else
      chk("registered_latency", {31'd0, s_iv}, 32'd0);
`endif
      for (int i = 3; i <= 12; i++) begin
         step();
         chk("stream_valid", {31'd0, s_iv}, 32'd1);
      end

      // 2: decode stalled -> exactly DEPTH requests, then release
      knobs(1, 1, 100, 0, 0, 0);
      do_reset();
      acc_cnt = 0;
      for (int i = 0; i < 20; i++) step();
      chk("fill_reqs", acc_cnt, DEPTH);
      chk("fill_stall", {31'd0, s_rdv}, 32'd0);
      p_irdy = 100; deq_cnt = 0;
      for (int i = 0; i < 12; i++) step();
      chk("drain_progress", {31'd0, deq_cnt >= DEPTH}, 32'd1);
      chk("fetch_resumed", {31'd0, acc_cnt > DEPTH}, 32'd1);

      // 3: latency 3, redirect with requests in flight
      knobs(3, 3, 100, 100, 0, 0);
      do_reset();
      step(); step();
      force_redir = 1'b1; force_pc = 32'h00020002;
      step();
      force_redir = 1'b0;
      redir_cyc = cyc; first_req = 0; got_it = 0;
      for (int i = 0; i < 12 && !got_it; i++) begin
         step();
         if (s_rdv) begin
            got_it = 1; first_req = cyc;
            chk("redir_req_addr", s_addr, 32'h00020000);
         end
      end
      chk("redir_req_seen", {31'd0, got_it}, 32'd1);
      chk("drain_cycles", first_req - redir_cyc, 4);
      got_it = 0;
      for (int i = 0; i < 12 && !got_it; i++) begin
         step();
         if (s_iv) begin
            got_it = 1;
            chk("redir_first_pc", s_pc, 32'h00020000);
         end
      end
      chk("redir_head_seen", {31'd0, got_it}, 32'd1);

      // 4: redirect coincident with dequeue and response
      knobs(1, 1, 100, 100, 0, 0);
      do_reset();
      for (int i = 0; i < 6; i++) step();
      force_redir = 1'b1; force_pc = 32'h00030000;
      step();
      force_redir = 1'b0;
      chk("coincide_pre", {31'd0, s_deq && s_rsp}, 32'd1);
      step();
      chk("coincide_empty", {31'd0, s_iv}, 32'd0);
      for (int i = 0; i < 10; i++) step();

      // 5: reset mid-stream with a partly full queue
      knobs(1, 2, 100, 30, 0, 0);
      do_reset();
      for (int i = 0; i < 8; i++) step();
      do_reset();
      step();
      chk("post_rst_req", {31'd0, s_rdv}, 32'd1);
      chk("post_rst_addr", s_addr, RESET_PC);
      chk("post_rst_empty", {31'd0, s_iv}, 32'd0);

      // random segments checked against the sequential-stream model
      deq_cnt = 0;
      for (int seg = 0; seg < 8; seg++) begin
         int lmin;
         lmin = $urandom_range(3, 1);
         knobs(lmin, lmin + $urandom_range(3), $urandom_range(100, 30),
               $urandom_range(100, 20), $urandom_range(8, 1), 2);
         do_reset();
         for (int i = 0; i < 300; i++) step();
      end
      chk("random_progress", {31'd0, deq_cnt > 200}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
